sorted_run_merger: RTL and testbench

Streaming two-way merger placed downstream of the bitonic `sorter`. It accepts two independently sorted runs of `SIZE` values each, one element per handshake on port A and one on port B. It emits one merged sorted run of `2*SIZE` values on a single valid/ready output stream. Chaining instances lets the design merge sorter output blocks into runs longer than one sorter can hold.

---
 rtl/sort_pkg.sv | 13 +
 rtl/merge_select.sv | 37 +++
 rtl/sorted_run_merger.sv | 140 ++++++++++++++
 tb/tb_sorted_run_merger.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sorter family: merge direction constants and merge FSM states.
package sort_pkg;

    localparam int unsigned DIR_ASC  = 0;
    localparam int unsigned DIR_DESC = 1;

    typedef enum logic [1:0] {
        MERGE   = 2'd0,
        DRAIN_A = 2'd1,
        DRAIN_B = 2'd2
    } merge_state_t;

endpackage

// File: rtl/merge_select.sv
// Two-way merge selector: picks which input feeds the output given the merge state.
// Ties favour A so the merge is stable with respect to A.
module merge_select
    import sort_pkg::*;
#(
    parameter int unsigned VALUE_BITS = 8,
    parameter int unsigned DIRECTION  = DIR_ASC
) (
    input  merge_state_t          state,
    input  logic [VALUE_BITS-1:0] a_data,
    input  logic [VALUE_BITS-1:0] b_data,
    output logic                  select_a,
    output logic [VALUE_BITS-1:0] sel_data
);

    logic a_first;

    always_comb begin
        if (DIRECTION == DIR_DESC) begin
            a_first = (a_data >= b_data);
        end else begin
            a_first = (a_data <= b_data);
        end
    end

    always_comb begin
        select_a = 1'b0;
        case (state)
            MERGE:   select_a = a_first;
            DRAIN_A: select_a = 1'b1;
            default: select_a = 1'b0;
        endcase
    end

    assign sel_data = select_a ? a_data : b_data;

endmodule

// File: rtl/sorted_run_merger.sv
// Streaming merge of two sorted runs of SIZE values into one sorted run of 2*SIZE values,
// with a registered valid/ready output and out_last on the final element of each run pair.
module sorted_run_merger
    import sort_pkg::*;
#(
    parameter int unsigned VALUE_BITS = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DIRECTION  = DIR_ASC,
    parameter int unsigned SIZE       = 1 << DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [VALUE_BITS-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [VALUE_BITS-1:0] b_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VALUE_BITS-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned      CNT_W    = DEPTH + 1;
    localparam int unsigned      SUM_W    = DEPTH + 2;
    localparam logic [CNT_W-1:0] RUN_LEN  = CNT_W'(SIZE);
    localparam logic [SUM_W-1:0] LAST_IDX = SUM_W'(2 * SIZE - 1);

    merge_state_t          state;
    merge_state_t          state_nxt;
    logic [CNT_W-1:0]      cnt_a;
    logic [CNT_W-1:0]      cnt_b;
    logic [CNT_W-1:0]      cnt_a_nxt;
    logic [CNT_W-1:0]      cnt_b_nxt;
    logic                  select_a;
    logic [VALUE_BITS-1:0] sel_data;
    logic                  src_valid;
    logic                  adv;
    logic                  consume;
    logic                  last_consume;

    merge_select #(
        .VALUE_BITS (VALUE_BITS),
        .DIRECTION  (DIRECTION)
    ) u_merge_select (
        .state    (state),
        .a_data   (a_data),
        .b_data   (b_data),
        .select_a (select_a),
        .sel_data (sel_data)
    );

    assign adv = !out_valid || out_ready;

    // While draining, the exhausted port's valid is ignored.
    always_comb begin
        src_valid = 1'b0;
        case (state)
            MERGE:   src_valid = a_valid && b_valid;
            DRAIN_A: src_valid = a_valid;
            default: src_valid = b_valid;
        endcase
    end

    assign consume      = adv && src_valid && !rst;
    assign last_consume = consume && ((SUM_W'(cnt_a) + SUM_W'(cnt_b)) == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MERGE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, together with the post-consume counter values it depends on
    always_comb begin
        state_nxt = state;
        cnt_a_nxt = cnt_a;
        cnt_b_nxt = cnt_b;
        if (consume) begin
            if (last_consume) begin
                cnt_a_nxt = '0;
                cnt_b_nxt = '0;
                state_nxt = MERGE;
            end else begin
                if (select_a) begin
                    cnt_a_nxt = cnt_a + CNT_W'(1);
                end else begin
                    cnt_b_nxt = cnt_b + CNT_W'(1);
                end
                if (cnt_a_nxt == RUN_LEN) begin
                    state_nxt = DRAIN_B;
                end else if (cnt_b_nxt == RUN_LEN) begin
                    state_nxt = DRAIN_A;
                end else begin
                    state_nxt = MERGE;
                end
            end
        end
    end

    // Handshake outputs; combinational on valid by design
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (consume) begin
            a_ready = select_a;
            b_ready = !select_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            cnt_a <= cnt_a_nxt;
            cnt_b <= cnt_b_nxt;
        end
    end

    // Output register holds its contents while the downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= consume;
            if (consume) begin
                out_data <= sel_data;
                out_last <= last_consume;
            end
        end
    end

endmodule

// File: tb/tb_sorted_run_merger.sv
// Randomized scoreboard bench for sorted_run_merger: an ascending and a descending instance,
// each checked against a stable-sort reference of the concatenated input runs.
module tb_sorted_run_merger;
    import sort_pkg::*;

    localparam int unsigned VB    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SIZE  = 1 << DEPTH;
    localparam int unsigned RUN   = 2 * SIZE;

    typedef logic [VB-1:0] run_t [SIZE];

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid   [2];
    logic          a_ready   [2];
    logic [VB-1:0] a_data    [2];
    logic          b_valid   [2];
    logic          b_ready   [2];
    logic [VB-1:0] b_data    [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [VB-1:0] out_data  [2];
    logic          out_last  [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [VB:0] exp_q0[$];
    logic [VB:0] exp_q1[$];

    always #5 clk = ~clk;

    sorted_run_merger #(.VALUE_BITS(VB), .DEPTH(DEPTH), .DIRECTION(DIR_ASC)) u_asc (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_data(a_data[0]),
        .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_data(b_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_last(out_last[0])
    );

    sorted_run_merger #(.VALUE_BITS(VB), .DEPTH(DEPTH), .DIRECTION(DIR_DESC)) u_desc (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_data(a_data[1]),
        .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_data(b_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_last(out_last[1])
    );

    task automatic check(input string name, input int k, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %0d, expected %0d", name, k, $time, got, want);
        end
    endtask

    task automatic fail_now(input string name, input int k);
        n_checks++;
        n_fail++;
        $display("FAIL %s inst%0d @%0t", name, k, $time);
    endtask

    // Reference: the merged run is the stable sort of A followed by B (A wins ties).
    task automatic push_expected(input int k, input run_t a, input run_t b);
        int key[RUN];
        int v;
        int tmp;
        for (int i = 0; i < RUN; i++) begin
            v      = (i < SIZE) ? int'(a[i]) : int'(b[i - SIZE]);
            if (k == 1) v = 255 - v;
            key[i] = v * RUN + i;
        end
        for (int i = 1; i < RUN; i++) begin
            for (int j = i; j > 0 && key[j-1] > key[j]; j--) begin
                tmp      = key[j];
                key[j]   = key[j-1];
                key[j-1] = tmp;
            end
        end
        for (int i = 0; i < RUN; i++) begin
            v = key[i] / RUN;
            if (k == 1) v = 255 - v;
            if (k == 0) exp_q0.push_back({(i == RUN - 1), VB'(v)});
            else        exp_q1.push_back({(i == RUN - 1), VB'(v)});
        end
    endtask

    task automatic gen_run(input bit desc, output run_t r);
        logic [VB-1:0] tmp;
        for (int i = 0; i < SIZE; i++) r[i] = VB'($urandom_range(255));
        for (int i = 1; i < SIZE; i++) begin
            for (int j = i; j > 0 && (desc ? (r[j-1] < r[j]) : (r[j-1] > r[j])); j--) begin
                tmp    = r[j];
                r[j]   = r[j-1];
                r[j-1] = tmp;
            end
        end
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks stall behaviour.
    logic [VB:0] held    [2];
    bit          stalled [2];

    always begin
        @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                stalled[k] = 1'b0;
            end else begin
                if (stalled[k]) begin
                    check("hold_valid", k, int'(out_valid[k]), 1);
                    check("hold_data", k, int'(out_data[k]), int'(held[k][VB-1:0]));
                    check("hold_last", k, int'(out_last[k]), int'(held[k][VB]));
                end
                if (out_valid[k] && !out_ready[k]) begin
                    check("stall_a_ready", k, int'(a_ready[k]), 0);
                    check("stall_b_ready", k, int'(b_ready[k]), 0);
                    stalled[k] = 1'b1;
                    held[k]    = {out_last[k], out_data[k]};
                end else begin
                    stalled[k] = 1'b0;
                end
                if (out_valid[k] && out_ready[k]) begin
                    logic [VB:0] want;
                    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                        fail_now("unexpected_output", k);
                    end else begin
                        want = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check("out_data", k, int'(out_data[k]), int'(want[VB-1:0]));
                        check("out_last", k, int'(out_last[k]), int'(want[VB]));
                    end
                end
            end
        end
    end

    // mode 0: full rate; 1: out_ready low 5 cycles after the 7th output; 2: random gaps.
    task automatic run_pair(input int k, input run_t a, input run_t b, input int mode,
                            input int abort_after);
        int ai = 0;
        int bi = 0;
        int nout = 0;
        int stall = 0;
        int cyc = 0;
        bit done = 1'b0;
        push_expected(k, a, b);
        while (!done) begin
            @(negedge clk);
            a_valid[k] = (ai < SIZE) && (mode != 2 || $urandom_range(3) != 0);
            a_data[k]  = (ai < SIZE) ? a[ai] : VB'($urandom_range(255));
            b_valid[k] = (bi < SIZE) && (mode != 2 || $urandom_range(3) != 0);
            b_data[k]  = (bi < SIZE) ? b[bi] : VB'($urandom_range(255));
            if (mode == 1) begin
                out_ready[k] = !(nout >= 7 && stall < 5);
                if (!out_ready[k]) stall++;
            end else if (mode == 2) begin
                out_ready[k] = ($urandom_range(2) != 0);
            end else begin
                out_ready[k] = 1'b1;
            end
            #1;
            if (a_valid[k] && a_ready[k]) ai++;
            if (b_valid[k] && b_ready[k]) bi++;
            if (out_valid[k] && out_ready[k]) nout++;
            cyc++;
            if (abort_after > 0 && nout == abort_after) begin
                @(negedge clk);
                rst        = 1'b1;
                a_valid[k] = 1'b1;
                b_valid[k] = 1'b1;
                #1;
                check("rst_out_valid", k, int'(out_valid[k]), 0);
                check("rst_out_data", k, int'(out_data[k]), 0);
                check("rst_out_last", k, int'(out_last[k]), 0);
                check("rst_a_ready", k, int'(a_ready[k]), 0);
                check("rst_b_ready", k, int'(b_ready[k]), 0);
                if (k == 0) exp_q0.delete();
                else        exp_q1.delete();
                @(negedge clk);
                rst  = 1'b0;
                done = 1'b1;
            end else if (nout == RUN) begin
                done = 1'b1;
            end else if (cyc > 3000) begin
                fail_now("run_timeout", k);
                done = 1'b1;
            end
        end
        a_valid[k]   = 1'b0;
        b_valid[k]   = 1'b0;
        out_ready[k] = 1'b1;
        @(negedge clk);
        #3;
        check("scoreboard_left", k, (k == 0) ? exp_q0.size() : exp_q1.size(), 0);
    endtask

    initial begin
        run_t ra;
        run_t rb;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_valid[k] = 1'b0; b_valid[k] = 1'b0;
            a_data[k] = '0;    b_data[k] = '0;
            out_ready[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            a_valid[k] = 1'b1;
            b_valid[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_out_valid", k, int'(out_valid[k]), 0);
            check("reset_out_data", k, int'(out_data[k]), 0);
            check("reset_out_last", k, int'(out_last[k]), 0);
            check("reset_a_ready", k, int'(a_ready[k]), 0);
            check("reset_b_ready", k, int'(b_ready[k]), 0);
            a_valid[k] = 1'b0;
            b_valid[k] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;

        // Interleave
        for (int i = 0; i < SIZE; i++) begin ra[i] = VB'(2 * i); rb[i] = VB'(2 * i + 1); end
        run_pair(0, ra, rb, 0, 0);
        // Disjoint runs
        for (int i = 0; i < SIZE; i++) begin ra[i] = VB'(i); rb[i] = VB'(100 + i); end
        run_pair(0, ra, rb, 0, 0);
        // Disjoint, B side smaller
        run_pair(0, rb, ra, 0, 0);
        // Ties
        for (int i = 0; i < SIZE; i++) begin ra[i] = VB'(5); rb[i] = VB'(5); end
        run_pair(0, ra, rb, 0, 0);
        // Backpressure on the interleave pattern
        for (int i = 0; i < SIZE; i++) begin ra[i] = VB'(2 * i); rb[i] = VB'(2 * i + 1); end
        run_pair(0, ra, rb, 1, 0);
        // Random sorted runs with random valid gaps and backpressure
        for (int t = 0; t < 6; t++) begin
            gen_run(1'b0, ra);
            gen_run(1'b0, rb);
            run_pair(0, ra, rb, 2, 0);
        end
        // Reset mid-run, then a fresh pair
        for (int i = 0; i < SIZE; i++) begin ra[i] = VB'(2 * i); rb[i] = VB'(2 * i + 1); end
        run_pair(0, ra, rb, 0, 7);
        run_pair(0, ra, rb, 0, 0);
        // Descending instance
        for (int i = 0; i < SIZE; i++) begin ra[i] = VB'(30 - 2 * i); rb[i] = VB'(31 - 2 * i); end
        run_pair(1, ra, rb, 0, 0);
        for (int t = 0; t < 4; t++) begin
            gen_run(1'b1, ra);
            gen_run(1'b1, rb);
            run_pair(1, ra, rb, 2, 0);
        end
        for (int i = 0; i < SIZE; i++) begin ra[i] = VB'(9); rb[i] = VB'(9); end
        run_pair(1, ra, rb, 1, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
